// File: rtl/svi_data_fifo_sink.sv
// svi_data_fifo_sink: FWFT FIFO consumer for the producer's data word.
// Checks each accepted word against EXP_VAL and counts accepted words.
module svi_data_fifo_sink #(
    parameter int unsigned        DATA_W  = 8,
    parameter int unsigned        DEPTH   = 4,
    parameter logic [DATA_W-1:0]  EXP_VAL = {DATA_W{1'b1}}
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_mismatch,
    output logic [15:0]              o_word_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          mismatch_q, mismatch_d;
    logic [15:0]   word_cnt_q, word_cnt_d;

    logic push;
    logic pop;

    // Handshake and head-of-queue outputs, all from registered occupancy
    always_comb begin
        o_ready    = (count_q != FULL);
        o_valid    = (count_q != '0);
        push       = i_valid & o_ready;
        pop        = o_valid & i_ready;
        o_data     = o_valid ? mem_q[rd_ptr_q] : '0;
        o_count    = count_q;
        o_mismatch = mismatch_q;
        o_word_cnt = word_cnt_q;
    end

    // Next-state: pointers, occupancy, sticky checker, saturating count
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        word_cnt_d = word_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (i_data != EXP_VAL) begin
                mismatch_d = 1'b1;
            end
            if (word_cnt_q != 16'hFFFF) begin
                word_cnt_d = word_cnt_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Storage array: written only on an accepted push, never reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_svi_data_fifo_sink.sv
// tb_svi_data_fifo_sink: directed stimulus with a reference model,
// an expected-data queue and a negedge monitor for svi_data_fifo_sink.
module tb_svi_data_fifo_sink;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic [2:0]  o_count;
    logic        o_mismatch;
    logic [15:0] o_word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp_q [$];
    int          m_cnt = 0;
    logic [15:0] m_wc  = '0;
    logic        m_mis = 1'b0;

    svi_data_fifo_sink dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_count    (o_count),
        .o_mismatch (o_mismatch),
        .o_word_cnt (o_word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: updates on the same edge as the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_wc  = '0;
            m_mis = 1'b0;
            exp_q.delete();
        end else begin
            logic mp;
            logic mq;
            mp = i_valid && (m_cnt != 4);
            mq = (m_cnt != 0) && i_ready;
            if (mp) begin
                exp_q.push_back(i_data);
                if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
                if (i_data != 8'hFF) m_mis = 1'b1;
            end
            m_cnt = m_cnt + int'(mp) - int'(mq);
        end
    end

    // Monitor: compares status every cycle, pops expected data on each pop
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 32'(o_count), m_cnt);
            chk("ready", 32'(o_ready), 32'(m_cnt != 4));
            chk("valid", 32'(o_valid), 32'(m_cnt != 0));
            chk("word_cnt", 32'(o_word_cnt), 32'(m_wc));
            chk("mismatch", 32'(o_mismatch), 32'(m_mis));
            if (o_valid && i_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("data", 32'(o_data), 32'(e));
                end
            end else if (!o_valid) begin
                chk("data_empty", 32'(o_data), 0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 8'h00;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 16 && o_valid; k++) tick();
        chk("drain_empty", 32'(o_valid), 0);
        i_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 8'h00;

        // 1: reset state and single push latency
        do_reset();
        chk("t1_rst_valid", 32'(o_valid), 0);
        chk("t1_rst_count", 32'(o_count), 0);
        chk("t1_rst_ready", 32'(o_ready), 1);
        chk("t1_rst_wc", 32'(o_word_cnt), 0);
        i_valid = 1'b1;
        i_data  = 8'hFF;
        #1 chk("t1_no_bypass", 32'(o_valid), 0);
        tick();
        i_valid = 1'b0;
        chk("t1_valid", 32'(o_valid), 1);
        chk("t1_data", 32'(o_data), 32'hFF);
        chk("t1_count", 32'(o_count), 1);
        chk("t1_wc", 32'(o_word_cnt), 1);
        chk("t1_mis", 32'(o_mismatch), 0);

        // 2: fill to full, ignored push while full, then drain
        do_reset();
        i_valid = 1'b1;
        i_data  = 8'hFF;
        repeat (4) tick();
        chk("t2_full_count", 32'(o_count), 4);
        chk("t2_full_ready", 32'(o_ready), 0);
        i_data = 8'h00;
        tick();
        i_valid = 1'b0;
        chk("t2_ign_wc", 32'(o_word_cnt), 4);
        chk("t2_ign_mis", 32'(o_mismatch), 0);
        chk("t2_ign_count", 32'(o_count), 4);
        i_ready = 1'b1;
        repeat (4) tick();
        i_ready = 1'b0;
        chk("t2_out_count", 32'(o_count), 0);
        chk("t2_out_valid", 32'(o_valid), 0);

        // 3: streaming, one word per cycle, pointers wrap
        do_reset();
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data  = 8'hFF;
        repeat (20) tick();
        i_valid = 1'b0;
        chk("t3_count", 32'(o_count), 1);
        chk("t3_wc", 32'(o_word_cnt), 20);
        drain();

        // 4: sticky mismatch
        do_reset();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hFF;
        tick();
        chk("t4_mis_pre", 32'(o_mismatch), 0);
        i_data = 8'hFE;
        tick();
        chk("t4_mis_set", 32'(o_mismatch), 1);
        i_data = 8'hFF;
        repeat (3) tick();
        chk("t4_mis_hold", 32'(o_mismatch), 1);
        drain();

        // 5: asynchronous reset while holding three words
        i_valid = 1'b1;
        i_data  = 8'hFF;
        repeat (3) tick();
        i_valid = 1'b0;
        chk("t5_count3", 32'(o_count), 3);
        chk("t5_mis_kept", 32'(o_mismatch), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(o_valid), 0);
        chk("t5_async_count", 32'(o_count), 0);
        chk("t5_async_wc", 32'(o_word_cnt), 0);
        chk("t5_async_mis", 32'(o_mismatch), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hFF;
        tick();
        i_valid = 1'b0;
        chk("t5_rb_data", 32'(o_data), 32'hFF);
        chk("t5_rb_count", 32'(o_count), 1);
        drain();

        // 6: word counter saturation
        do_reset();
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data  = 8'hFF;
        repeat (65533) tick();
        chk("t6_wc_fffd", 32'(o_word_cnt), 32'hFFFD);
        tick();
        chk("t6_wc_fffe", 32'(o_word_cnt), 32'hFFFE);
        tick();
        chk("t6_wc_ffff", 32'(o_word_cnt), 32'hFFFF);
        tick();
        chk("t6_wc_sat", 32'(o_word_cnt), 32'hFFFF);
        drain();

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
